// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache. Hits answer in the same cycle; a miss stalls
// the core while one line is refilled from backing memory, one acked beat per word.
module icache_2way #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);
  localparam int TAG_W = 32 - 2 - OFFSET_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_e;

  state_e              state_q, state_d;
  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     valid_d [2];
  logic [SETS-1:0]     lru_q, lru_d;
  logic [TAG_W-1:0]    tag_q [2][SETS];
  logic [TAG_W-1:0]    tag_d [2][SETS];
  logic [31:0]         data_q [2][SETS][WORDS];
  logic [31:0]         data_d [2][SETS][WORDS];
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;
  logic                victim_q, victim_d;
  logic [OFFSET_W-1:0] beat_q, beat_d, beat_nxt;
  logic                flush_pend_q, flush_pend_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_word;
  logic                hit0, hit1;
  logic [31:0]         rdata;
  logic                stall;
  logic                unused_addr_bits;

  assign req_tag          = rom_addr_i[31 -: TAG_W];
  assign req_idx          = rom_addr_i[OFFSET_W+2 +: INDEX_W];
  assign req_word         = rom_addr_i[2 +: OFFSET_W];
  assign unused_addr_bits = ^rom_addr_i[1:0];
  assign hit0 = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1 = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign beat_nxt = beat_q + OFFSET_W'(1);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    lru_d        = lru_q;
    tag_d        = tag_q;
    data_d       = data_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    victim_d     = victim_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    rdata        = '0;
    stall        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rom_ce_i) begin
          if (hit0 || hit1) begin
            rdata          = hit0 ? data_q[0][req_idx][req_word] : data_q[1][req_idx][req_word];
            lru_d[req_idx] = hit0;
          end else begin
            stall      = 1'b1;
            miss_tag_d = req_tag;
            miss_idx_d = req_idx;
            // Prefer an empty way so a fresh set never evicts live data.
            victim_d   = !valid_q[0][req_idx] ? 1'b0 :
                         !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
            beat_d     = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}, 2'b00};
            state_d    = REFILL;
          end
        end
        if (flush_i) begin
          valid_d[0] = '0;
          valid_d[1] = '0;
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_ack_i && mem_req_q) begin
          data_d[victim_q][miss_idx_q][beat_q] = mem_data_i;
          beat_d = beat_nxt;
          if (beat_q == OFFSET_W'(WORDS - 1)) begin
            tag_d[victim_q][miss_idx_q]   = miss_tag_q;
            valid_d[victim_q][miss_idx_q] = 1'b1;
            lru_d[miss_idx_q]             = ~victim_q;
            mem_req_d                     = 1'b0;
            state_d                       = DONE;
          end else begin
            mem_addr_d = {miss_tag_q, miss_idx_q, beat_nxt, 2'b00};
          end
        end
      end
      DONE: begin
        stall = 1'b1;
        // A flush seen during the refill also drops the line just installed.
        if (flush_pend_q || flush_i) begin
          valid_d[0] = '0;
          valid_d[1] = '0;
        end
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      lru_q        <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      lru_q        <= lru_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign rom_data_o = rst ? 32'h0 : rdata;
  assign stallreq_o = rst ? 1'b0 : stall;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
endmodule

// File: tb/tb_icache_2way.sv
// Bench for icache_2way: directed scenarios plus random fetches against a per-set
// two-entry recency model of the cache and an address-derived backing memory.
module tb_icache_2way;
  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int n_checks = 0;
  int n_errors = 0;

  icache_2way dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .stallreq_o (stallreq_o),
    .flush_i    (flush_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per set, slot 0 holds the most recently used tag, slot 1 the other.
  bit          m_vld0 [32];
  bit          m_vld1 [32];
  logic [22:0] m_tag0 [32];
  logic [22:0] m_tag1 [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit model_hit(input logic [22:0] tag, input logic [4:0] idx);
    return (m_vld0[idx] && m_tag0[idx] == tag) || (m_vld1[idx] && m_tag1[idx] == tag);
  endfunction

  task automatic model_flush();
    for (int s = 0; s < 32; s++) begin
      m_vld0[s] = 1'b0;
      m_vld1[s] = 1'b0;
    end
  endtask

  task automatic model_touch(input logic [22:0] tag, input logic [4:0] idx);
    logic [22:0] t;
    if (!(m_vld0[idx] && m_tag0[idx] == tag)) begin
      t = m_tag0[idx];
      m_tag0[idx] = m_tag1[idx];
      m_tag1[idx] = t;
      m_vld1[idx] = m_vld0[idx];
      m_vld0[idx] = 1'b1;
    end
  endtask

  task automatic model_insert(input logic [22:0] tag, input logic [4:0] idx);
    m_vld1[idx] = m_vld0[idx];
    m_tag1[idx] = m_tag0[idx];
    m_vld0[idx] = 1'b1;
    m_tag0[idx] = tag;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rom_ce_i = 1'b1; rom_addr_i = 32'h0; flush_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    check("rst_stall", stallreq_o, 1'b0);
    check("rst_data", rom_data_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rom_ce_i = 1'b0;
    @(negedge clk);
    check("rst_req", mem_req_o, 1'b0);
    check("rst_maddr", mem_addr_o, 32'h0);
    check("rst_idle_stall", stallreq_o, 1'b0);
    model_flush();
  endtask

  // flush_mode: 0 none, 1 in lookup cycle, 2 at start of beat 1, 3 random during refill/DONE.
  task automatic fetch(input logic [31:0] addr, input int flush_mode, input int gap_max,
                       input int hold_beat, output bit was_hit);
    logic [22:0] tag;
    logic [4:0]  idx;
    logic [31:0] line;
    bit          exp_hit;
    bit          pend;
    int          gap;
    tag  = addr[31:9];
    idx  = addr[8:4];
    line = {addr[31:4], 4'h0};
    @(posedge clk); #1;
    rom_ce_i = 1'b1; rom_addr_i = addr; flush_i = (flush_mode == 1);
    mem_ack_i = 1'($urandom_range(0, 1)); mem_data_i = $urandom;
    @(negedge clk);
    exp_hit = model_hit(tag, idx);
    was_hit = !stallreq_o;
    check("lookup_stall", stallreq_o, !exp_hit);
    check("lookup_req", mem_req_o, 1'b0);
    if (exp_hit) begin
      check("hit_data", rom_data_o, memword({addr[31:2], 2'b00}));
      model_touch(tag, idx);
    end else begin
      check("miss_data", rom_data_o, 32'h0);
    end
    if (flush_mode == 1) model_flush();
    if (!exp_hit) begin
      pend = 1'b0;
      for (int b = 0; b < 4; b++) begin
        gap = (b == hold_beat) ? 10 : $urandom_range(0, gap_max);
        for (int g = 0; g <= gap; g++) begin
          @(posedge clk); #1;
          mem_ack_i  = (g == gap);
          mem_data_i = mem_ack_i ? memword(line + 32'(4 * b)) : $urandom;
          rom_ce_i   = (b == hold_beat) ? 1'b1 : 1'($urandom_range(0, 1));
          rom_addr_i = (b == hold_beat) ? 32'h40 : $urandom;
          flush_i    = (flush_mode == 2 && b == 1 && g == 0) ||
                       (flush_mode == 3 && $urandom_range(0, 7) == 0);
          if (flush_i) pend = 1'b1;
          @(negedge clk);
          check("refill_req", mem_req_o, 1'b1);
          check("refill_maddr", mem_addr_o, line + 32'(4 * b));
          check("refill_stall", stallreq_o, 1'b1);
          check("refill_data", rom_data_o, 32'h0);
        end
      end
      @(posedge clk); #1;
      mem_ack_i  = 1'($urandom_range(0, 1));
      mem_data_i = $urandom;
      flush_i    = (flush_mode == 3 && $urandom_range(0, 7) == 0);
      if (flush_i) pend = 1'b1;
      rom_ce_i   = 1'b1;
      rom_addr_i = addr;
      @(negedge clk);
      check("done_stall", stallreq_o, 1'b1);
      check("done_req", mem_req_o, 1'b0);
      model_insert(tag, idx);
      if (pend) model_flush();
    end
    @(posedge clk); #1;
    rom_ce_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    check("idle_stall", stallreq_o, 1'b0);
    check("idle_data", rom_data_o, 32'h0);
  endtask

  initial begin
    bit h;
    logic [31:0] a;
    int fm;
    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = 32'h0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    model_flush();
    do_reset();

    // Cold miss, then the refilled line serves sequential fetches.
    fetch(32'h0, 0, 0, -1, h);  check("cold_miss", h, 1'b0);
    fetch(32'h0, 0, 0, -1, h);  check("refill_hit", h, 1'b1);
    fetch(32'h4, 0, 0, -1, h);  check("seq_hit4", h, 1'b1);
    fetch(32'h8, 0, 0, -1, h);  check("seq_hit8", h, 1'b1);
    fetch(32'hC, 0, 0, -1, h);  check("seq_hitC", h, 1'b1);

    // LRU eviction within set 0.
    do_reset();
    fetch(32'h000, 0, 1, -1, h);
    fetch(32'h200, 0, 1, -1, h);
    fetch(32'h000, 0, 0, -1, h); check("touch_hit", h, 1'b1);
    fetch(32'h400, 0, 1, -1, h); check("conflict_miss", h, 1'b0);
    fetch(32'h000, 0, 0, -1, h); check("lru_kept", h, 1'b1);
    fetch(32'h200, 0, 0, -1, h); check("lru_evicted", h, 1'b0);

    // Withheld ack while the fetch address wanders to 0x40.
    do_reset();
    fetch(32'h0, 0, 0, 2, h);
    fetch(32'h0, 0, 0, -1, h);  check("hold_hit", h, 1'b1);
    fetch(32'h40, 0, 0, -1, h); check("hold_other_miss", h, 1'b0);

    // Flush in IDLE: same-cycle lookup still hits, next one misses.
    fetch(32'h0, 1, 0, -1, h);  check("flush_same_cycle_hit", h, 1'b1);
    fetch(32'h0, 0, 0, -1, h);  check("flush_after_miss", h, 1'b0);

    // Flush during refill drops the line once DONE completes.
    fetch(32'h80, 2, 0, -1, h); check("flushref_miss", h, 1'b0);
    fetch(32'h80, 0, 0, -1, h); check("flushref_remiss", h, 1'b0);

    // Reset in the middle of a refill.
    do_reset();
    @(posedge clk); #1;
    rom_ce_i = 1'b1; rom_addr_i = 32'h300;
    @(negedge clk);
    check("rm_miss_stall", stallreq_o, 1'b1);
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      mem_ack_i = 1'b1; mem_data_i = memword(32'h300 + 32'(4 * b));
      @(negedge clk);
      check("rm_maddr", mem_addr_o, 32'h300 + 32'(4 * b));
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rm_rst_stall", stallreq_o, 1'b0);
    check("rm_rst_data", rom_data_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rom_ce_i = 1'b0;
    @(negedge clk);
    check("rm_req", mem_req_o, 1'b0);
    check("rm_stall", stallreq_o, 1'b0);
    check("rm_maddr0", mem_addr_o, 32'h0);
    model_flush();
    fetch(32'h300, 0, 0, -1, h); check("rm_old_miss", h, 1'b0);

    // Random fetches over a few conflicting sets.
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      fm = $urandom_range(0, 19);
      fm = (fm == 0) ? 1 : (fm == 1) ? 3 : 0;
      fetch(a, fm, 2, -1, h);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
